demux4_stream: RTL and testbench
================================

Name: demux4_stream

Overview:
- Inverse of the team's 4:1 mux: one WIDTH-bit input stream, steered by a 2-bit sel to one of four output channels (a, b, c, d).
- Each output channel has a one-entry holding register with a valid/ready handshake, so one stalled consumer blocks only traffic addressed to it.
- Each channel has a wrap-around transfer counter for debug/observability.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of input and each output channel.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept the word addressed by sel this cycle.
- sel  input  2  destination channel: 0=a, 1=b, 2=c, 3=d.
- in_data  input  WIDTH  input word.
- out_a, out_b, out_c, out_d  output  WIDTH each  channel holding registers.
- out_valid  output  4  bit k = channel k holds a word (bit0=a … bit3=d).
- out_ready  input  4  bit k = consumer k takes the word this cycle.
- cnt  output  4*CNT_W  channel k transfer count at bits [k*CNT_W +: CNT_W].

Behaviour:
Clock and reset:
- Single clock clk; rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: out_valid=4'b0000, out_a..out_d=0, all cnt fields=0.
- While rst=1, in_ready=0 and input is ignored.
- Reset asserted mid-operation discards all held words; no transfer is counted in that cycle.

Handshake rules:
- in_ready = !rst && (!out_valid[sel] || out_ready[sel]); combinational.
- The producer must hold sel and in_data stable while in_valid=1 and in_ready=0.
- Accept: in_valid && in_ready at a clock edge.
- Drain of channel k: out_valid[k] && out_ready[k] at a clock edge.

Accept path:
- On accept, the register of channel sel loads in_data and out_valid[sel]=1 from the next cycle.
- Latency is 1 cycle, input to output.
- Full throughput: one word per cycle to any mix of channels while consumers are ready.

Drain path:
- On drain of channel k with no accept to k in the same cycle, out_valid[k] clears next cycle.
- Simultaneous drain and accept on the same channel: out_valid[k] stays 1 and the register takes the new word. No bubble and no loss.
- Accept to channel j and drain of a different channel k in the same cycle: both happen independently.

Output stability:
- While out_valid[k]=1 and out_ready[k]=0, out_k and out_valid[k] hold unchanged.
- A channel with out_valid=0 keeps its last data value; consumers ignore it.
- Channels not addressed keep their state.

Counters:
- cnt field k increments by 1 on each drain of channel k.
- Wraps from 2^CNT_W-1 to 0 with no flag.
- Counts drains, not accepts.

Other rules:
- All four sel values are legal; there is no illegal or default encoding.
- No internal FSM beyond the four per-channel states EMPTY (valid=0) and FULL (valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on accept+drain, or on stall.

Test Plan:
- Reset, then out_ready=4'b1111, in_valid=1, sel stepping 0,1,2,3 with in_data 1,2,3,4 -> out_a=1, out_b=2, out_c=3, out_d=4, each appearing with its out_valid bit exactly one cycle after accept; cnt fields a..d each =1.
- out_ready[1]=0, send in_data=5 then in_data=6 with sel=1 -> out_b=5 held, in_ready=0 on the second word. Meanwhile sel=2 with in_data=7 is accepted (out_c=7). Raise out_ready[1] -> 5 drains, 6 loads, and out_valid[1] stays 1 across the swap.
- Channel a full, out_ready[0]=1, new word 9 sent with sel=0 in the same cycle -> out_valid[0] remains 1, out_a=9 next cycle, cnt field a +1.
- CNT_W=8: drain channel d 256 times -> cnt field d wraps to 0.
- Fill all four channels with out_ready=0, then assert rst for one cycle -> out_valid=0, outputs and cnt=0, in_ready=0 during rst and 1 after.
- in_valid=0 with out_ready=4'b1111 on empty channels -> no out_valid rise and no counter change.

Source files
------------

// File: rtl/demux4_stream.sv
// demux4_stream: one input stream steered by sel to four channels,
// each with a one-entry holding register and a drain counter.
module demux4_stream #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         sel,
   input  logic [WIDTH-1:0]   in_data,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic [WIDTH-1:0]   out_c,
   output logic [WIDTH-1:0]   out_d,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*CNT_W-1:0] cnt
);

   logic [3:0]       valid_q;
   logic [3:0]       valid_d;
   logic [WIDTH-1:0] data_q [4];
   logic [WIDTH-1:0] data_d [4];
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   logic [3:0] sel_oh;
   logic       accept;
   logic [3:0] acc_k;
   logic [3:0] drain_k;

   // one-hot decode of the destination channel
   always_comb begin
      sel_oh = 4'b0000;
      unique case (sel)
         2'd0: sel_oh = 4'b0001;
         2'd1: sel_oh = 4'b0010;
         2'd2: sel_oh = 4'b0100;
         2'd3: sel_oh = 4'b1000;
      endcase
   end

   // addressed slot is free, or frees up this cycle
   always_comb begin
      in_ready = !rst && (!valid_q[sel] || out_ready[sel]);
   end

   // per-channel accept/drain strobes
   always_comb begin
      accept  = in_valid && in_ready;
      acc_k   = accept ? sel_oh : 4'b0000;
      drain_k = valid_q & out_ready;
   end

   // next state: a held word survives only while stalled
   always_comb begin
      valid_d = acc_k | (valid_q & ~out_ready);
      for (int k = 0; k < 4; k++) begin
         data_d[k] = acc_k[k] ? in_data : data_q[k];
         cnt_d[k]  = drain_k[k] ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
      end
   end

   // state registers; reset discards held words and counts
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= data_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
      end
   end

   // outputs come straight from the holding registers
   always_comb begin
      out_valid = valid_q;
      out_a     = data_q[0];
      out_b     = data_q[1];
      out_c     = data_q[2];
      out_d     = data_q[3];
   end

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed vectors with hand-computed
// expectations for demux4_stream.
module tb_demux4_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  sel;
   logic [3:0]  in_data;
   logic [3:0]  out_a, out_b, out_c, out_d;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] cnt;

   int vectors = 0;
   int miscompares = 0;

   demux4_stream #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .in_data   (in_data),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sel = 2'd0;
      in_data = 4'd0; out_ready = 4'b0000;
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_cnt", cnt, 32'h0);
      chk("rst_data", {16'h0, out_a, out_b, out_c, out_d}, 32'h0);
      chk("rst_inready", 32'(in_ready), 32'h0);
      rst = 1'b0; #1;
      chk("post_rst_inready", 32'(in_ready), 32'h1);

      // round robin fill, all consumers ready
      out_ready = 4'b1111; in_valid = 1'b1;
      sel = 2'd0; in_data = 4'd1; step();
      chk("rr_valid_a", 32'(out_valid), 32'h1);
      chk("rr_out_a", 32'(out_a), 32'h1);
      sel = 2'd1; in_data = 4'd2; step();
      chk("rr_valid_b", 32'(out_valid), 32'h2);
      chk("rr_out_b", 32'(out_b), 32'h2);
      sel = 2'd2; in_data = 4'd3; step();
      chk("rr_valid_c", 32'(out_valid), 32'h4);
      chk("rr_out_c", 32'(out_c), 32'h3);
      sel = 2'd3; in_data = 4'd4; step();
      chk("rr_valid_d", 32'(out_valid), 32'h8);
      chk("rr_out_d", 32'(out_d), 32'h4);
      in_valid = 1'b0; step();
      chk("rr_valid_end", 32'(out_valid), 32'h0);
      chk("rr_cnt", cnt, 32'h01010101);

      // channel b stalled, c keeps flowing
      out_ready = 4'b1101; in_valid = 1'b1;
      sel = 2'd1; in_data = 4'd5; #1;
      chk("stall_inready_b_empty", 32'(in_ready), 32'h1);
      step();
      chk("stall_valid_b", 32'(out_valid), 32'h2);
      chk("stall_out_b5", 32'(out_b), 32'h5);
      sel = 2'd2; in_data = 4'd7; #1;
      chk("stall_inready_c", 32'(in_ready), 32'h1);
      step();
      chk("stall_valid_bc", 32'(out_valid), 32'h6);
      chk("stall_out_c7", 32'(out_c), 32'h7);
      chk("stall_out_b_hold", 32'(out_b), 32'h5);
      sel = 2'd1; in_data = 4'd6; #1;
      chk("stall_inready_b_full", 32'(in_ready), 32'h0);
      step();
      chk("stall_valid_b_only", 32'(out_valid), 32'h2);
      chk("stall_out_b_still5", 32'(out_b), 32'h5);
      chk("stall_inready_still0", 32'(in_ready), 32'h0);
      out_ready = 4'b1111; #1;
      chk("swap_inready", 32'(in_ready), 32'h1);
      step();
      chk("swap_valid_b", 32'(out_valid), 32'h2);
      chk("swap_out_b6", 32'(out_b), 32'h6);
      chk("swap_cnt", cnt, 32'h01020201);
      in_valid = 1'b0; step();
      chk("swap_drained", 32'(out_valid), 32'h0);
      chk("swap_cnt2", cnt, 32'h01020301);

      // simultaneous drain and accept on channel a
      out_ready = 4'b0000; in_valid = 1'b1;
      sel = 2'd0; in_data = 4'd8; step();
      chk("pass_fill_a", 32'(out_a), 32'h8);
      out_ready = 4'b0001; in_data = 4'd9; #1;
      chk("pass_inready", 32'(in_ready), 32'h1);
      step();
      chk("pass_valid_a", 32'(out_valid), 32'h1);
      chk("pass_out_a9", 32'(out_a), 32'h9);
      chk("pass_cnt_a", cnt, 32'h01020302);
      in_valid = 1'b0; step();
      chk("pass_cnt_a2", cnt, 32'h01020303);

      // idle with ready consumers: nothing moves
      out_ready = 4'b1111;
      step(); step(); step();
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_cnt", cnt, 32'h01020303);

      // channel d counter wrap: 255 more drains
      in_valid = 1'b1; sel = 2'd3;
      for (int i = 0; i < 255; i++) begin
         in_data = 4'(i);
         step();
      end
      chk("wrap_valid_d", 32'(out_valid), 32'h8);
      chk("wrap_out_d", 32'(out_d), 32'hE);
      chk("wrap_cnt_ff", 32'(cnt[31:24]), 32'hFF);
      in_valid = 1'b0; step();
      chk("wrap_cnt_zero", 32'(cnt[31:24]), 32'h0);
      chk("wrap_others", 32'(cnt[23:0]), 32'h020303);

      // fill everything, then reset mid-operation
      out_ready = 4'b0000; in_valid = 1'b1;
      sel = 2'd0; in_data = 4'hA; step();
      sel = 2'd1; in_data = 4'hB; step();
      sel = 2'd2; in_data = 4'hC; step();
      sel = 2'd3; in_data = 4'hD; step();
      chk("full_valid", 32'(out_valid), 32'hF);
      chk("full_data", {16'h0, out_a, out_b, out_c, out_d}, 32'hABCD);
      in_valid = 1'b0; out_ready = 4'b1111; rst = 1'b1; #1;
      chk("mid_rst_inready", 32'(in_ready), 32'h0);
      step();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", {16'h0, out_a, out_b, out_c, out_d}, 32'h0);
      chk("mid_rst_cnt", cnt, 32'h0);
      chk("mid_rst_inready2", 32'(in_ready), 32'h0);
      rst = 1'b0; out_ready = 4'b0000; #1;
      chk("after_rst_inready", 32'(in_ready), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
